// File: rtl/key_index_encoder.sv
// rtl/key_index_encoder.sv - synchronised, debounced N-line key vector to binary index encoder
module key_index_encoder #(
    parameter  int N        = 8,
    parameter  int DEBOUNCE = 4,
    parameter  int PRIORITY = 0,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] data_in,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         multi,
    output logic         event_p
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ACC = CW'(DEBOUNCE - 1);

    logic [N-1:0]  r_s1;
    logic [N-1:0]  r_s2;
    logic [N-1:0]  r_cand;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_code;
    logic          r_valid;
    logic          r_multi;
    logic          r_event;

    logic          w_same;
    logic          w_accept;
    logic [PW-1:0] w_pop;
    logic [W-1:0]  w_hi;
    logic          w_valid;
    logic          w_multi;
    logic [W-1:0]  w_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= data_in;
            r_s2 <= r_s1;
        end
    end

    assign w_same   = (r_s2 == r_cand);
    assign w_accept = w_same && (r_cnt == CNT_ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (!w_same) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // On an accepting edge r_cand equals r_s2 and is the vector about to become stable.
    always_comb begin
        w_pop = '0;
        w_hi  = '0;
        for (int i = 0; i < N; i++) begin
            if (r_cand[i]) begin
                w_pop = w_pop + PW'(1);
                w_hi  = W'(i);
            end
        end
    end

    always_comb begin
        w_multi = (w_pop > PW'(1));
        if (PRIORITY != 0) begin
            w_valid = (w_pop != '0);
        end else begin
            w_valid = (w_pop == PW'(1));
        end
        w_code = w_valid ? w_hi : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
            r_event <= 1'b0;
        end else begin
            r_event <= 1'b0;
            if (w_accept) begin
                r_code  <= w_code;
                r_valid <= w_valid;
                r_multi <= w_multi;
                r_event <= ({w_valid, w_code} != {r_valid, r_code});
            end
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign multi   = r_multi;
    assign event_p = r_event;

endmodule

// File: doc/key_index_encoder.md
# key_index_encoder

Parametrised, registered one-hot/priority encoder for the keyboard front end. It takes N raw key or line inputs and synchronises them into the clock domain. It debounces the whole input vector, then produces a binary key index with valid, multi-hot and change-event flags. It feeds the note/tone selection logic and generalises the fixed 8-to-3 one-hot encoder to any width, with a selectable multi-key policy.

## Interface
- N, default 8: number of input lines; legal range N >= 2.
- DEBOUNCE, default 4: consecutive identical synchronised samples required before a vector is accepted; legal range DEBOUNCE >= 1.
- PRIORITY, default 0: multi-key policy.
  - 0: strict one-hot; any multi-hot vector is invalid.
  - 1: the highest set index wins.
- Derived localparam W = $clog2(N): code width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  N  raw asynchronous key lines; bit i = key i.
- code  out  W  accepted key index.
- valid  out  1  code is meaningful.
- multi  out  1  accepted vector has more than one bit set.
- event_p  out  1  one-cycle pulse when {valid, code} changes.

## Operation
- Synchroniser: two flops per bit, data_in -> s1 -> s2.
- Debounce state:
  - cand (N bits) holds the last sample; cnt has width $clog2(DEBOUNCE+1).
  - Each cycle, if s2 != cand: cand <= s2 and cnt <= 0.
  - Else, if cnt < DEBOUNCE: cnt <= cnt + 1. cnt saturates at DEBOUNCE.
  - Acceptance happens on the edge where cnt goes from DEBOUNCE-1 to DEBOUNCE with s2 == cand. On that edge stable <= cand.
  - While cnt is saturated, nothing is re-accepted.
- Encode (registered, on the same edge as acceptance, computed from the new stable value). Let pop = number of set bits in stable.
  - multi = (pop > 1) in both modes.
  - PRIORITY=0:
    - valid = (pop == 1).
    - code = index of the set bit when valid, else 0.
  - PRIORITY=1:
    - valid = (pop >= 1).
    - code = highest set index, else 0.
  - All-zero vector: valid=0, code=0, multi=0.
- Event: event_p = 1 for exactly one cycle on the acceptance edge if the new {valid, code} differs from the previous {valid, code}.
  - Otherwise event_p = 0.
  - In strict mode, a change only in multi, or between two invalid vectors, produces no event.
- Non-power-of-two N: inputs are treated the same way; code never exceeds N-1.

## Timing
- Reset (asynchronous assert, synchronous release by clk):
  - s1, s2, cand, stable = 0; cnt = 0.
  - code = 0, valid = 0, multi = 0, event_p = 0.
- Reset asserted mid-debounce discards the pending vector. After release the block behaves as from power-up.
- Latency: a data_in change that is stable before edge 1 is reflected on the outputs after edge DEBOUNCE+3. With the defaults that is edge 7.
- Glitch rejection:
  - A change that lasts fewer than DEBOUNCE samples at s2 is never accepted.
  - A return to the previously accepted vector produces no event, because {valid, code} is unchanged.
- A new change arriving on the acceptance edge itself: acceptance of the old cand still occurs, and the new value restarts cnt at 0 on the next edge.
- Outputs are stable between acceptance edges. event_p never lasts longer than 1 cycle. Back-to-back events are at least DEBOUNCE+1 cycles apart.

## Test plan
- Reset: hold rst_n=0 with data_in=8'hFF -> all outputs 0. After release with data_in=0, outputs stay 0 and event_p never fires.
- Single key, N=8, DEBOUNCE=4, PRIORITY=0: data_in 0 -> 8'h20 before edge 1 -> at edge 7, code=5, valid=1, multi=0, event_p=1 for one cycle. Returning to 0 -> valid=0, code=0 with one event pulse.
- Glitch: 8'h20 for 3 cycles, then back to 0 -> no output change and no event_p. Then 8'h80 held -> code=7 after DEBOUNCE+3 edges.
- Multi-hot strict: 8'h24 held -> valid=0, code=0, multi=1. event_p fires only if the previous accepted state was valid.
- Multi-hot priority (PRIORITY=1): 8'h24 -> code=5, valid=1, multi=1. Then 8'h04 -> code=2, multi=0, event_p=1.
- Width and reset: N=12, DEBOUNCE=1, data_in 12'h800 -> code=11 (4 bits) at edge 4. Asserting rst_n mid-debounce of 12'h001 clears all outputs to 0 immediately.
